// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Frame FIFO sitting behind a UART receiver. Each entry holds the received
// byte together with its parity and stop-bit error flags. Occupancy flags are
// registered and derived from the next-state count so they always agree with
// each other. Pops have one cycle of latency. A sticky overflow flag records
// lost frames, and a saturating counter tallies every errored frame seen.
module uart_rx_fifo #(
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int AF_LEVEL = 6,
  parameter int DROP_ERR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          rx_parity_err,
  input  logic          rx_stop_err,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_parity_err,
  output logic          rd_stop_err,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic [7:0]    err_cnt
);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  typedef logic [9:0]    entry_t;  // {stop_err, parity_err, data}

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AF_C    = cnt_t'(AF_LEVEL);

  // Storage and state
  entry_t      mem_q [DEPTH];
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  cnt_t        count_q, count_d;
  logic        empty_q, empty_d;
  logic        full_q, full_d;
  logic        af_q, af_d;
  logic        ovf_q, ovf_d;
  logic        rd_valid_q;
  logic [7:0]  rd_data_q;
  logic        rd_pe_q, rd_se_q;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // Per-cycle decisions
  logic        discard;
  logic        wr_accept;
  logic        wr_drop;
  logic        rd_accept;
  logic        frame_err;
  entry_t      rd_entry;

  // Classify the incoming frame and the pop request against the current flags.
  // Decisions use the registered full/empty, so a pop in the same cycle never
  // frees room for a write, and a write into an empty FIFO is never popped
  // in the same cycle.
  always_comb begin
    discard   = (DROP_ERR != 0) && rx_stop_err;
    frame_err = rx_parity_err | rx_stop_err;
    wr_accept = rx_valid && !full_q && !discard;
    wr_drop   = rx_valid &&  full_q && !discard;
    rd_accept = rd_en && !empty_q;
    rd_entry  = mem_q[rd_ptr_q];
  end

  // Next-state pointers, occupancy and flags.
  // NOTE: every output of this block is given a default first so that no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    err_cnt_d = err_cnt_q;

    // Pointers are AW bits wide and DEPTH is 2**AW, so they wrap naturally.
    if (wr_accept) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + ptr_t'(1);

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase

    // A lost frame wins over a clear arriving in the same cycle.
    if (wr_drop)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;

    // Errored frames are counted whether or not they end up stored.
    if (rx_valid && frame_err && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
    af_d    = (count_d >= AF_C);
  end

  // Control state, read-side output registers and status flags.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
      ovf_q      <= 1'b0;
      err_cnt_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_pe_q    <= 1'b0;
      rd_se_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      af_q       <= af_d;
      ovf_q      <= ovf_d;
      err_cnt_q  <= err_cnt_d;
      rd_valid_q <= rd_accept;
      // Popped data is held until the next successful pop.
      if (rd_accept) begin
        rd_data_q <= rd_entry[7:0];
        rd_pe_q   <= rd_entry[8];
        rd_se_q   <= rd_entry[9];
      end
    end
  end

  // Frame storage write port.
  // NOTE: the array has no reset; resetting the pointers and count is enough
  // to make stale contents unreachable, and it keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= {rx_stop_err, rx_parity_err, rx_data};
  end

  assign rd_data       = rd_data_q;
  assign rd_parity_err = rd_pe_q;
  assign rd_stop_err   = rd_se_q;
  assign rd_valid      = rd_valid_q;
  assign empty         = empty_q;
  assign full          = full_q;
  assign almost_full   = af_q;
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Table of directed vectors from reset, hand-written corner sequences, and a
// randomized run checked against a queue-based reference model. A second
// instance built with DROP_ERR=1 covers stop-error discarding.
module tb_uart_rx_fifo;

  localparam int DEPTH    = 8;
  localparam int AW       = 3;
  localparam int AF_LEVEL = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  // Main instance (DROP_ERR=0)
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_parity_err = 1'b0;
  logic          rx_stop_err = 1'b0;
  logic          rd_en = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_parity_err, rd_stop_err, rd_valid;
  logic          empty, full, almost_full, overflow;
  logic [AW:0]   count;
  logic [7:0]    err_cnt;

  // Second instance (DROP_ERR=1)
  logic          rx_valid_b = 1'b0;
  logic [7:0]    rx_data_b = 8'h00;
  logic          rx_parity_err_b = 1'b0;
  logic          rx_stop_err_b = 1'b0;
  logic          rd_en_b = 1'b0;
  logic          ovf_clr_b = 1'b0;
  logic [7:0]    rd_data_b;
  logic          rd_parity_err_b, rd_stop_err_b, rd_valid_b;
  logic          empty_b, full_b, almost_full_b, overflow_b;
  logic [AW:0]   count_b;
  logic [7:0]    err_cnt_b;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .AF_LEVEL(AF_LEVEL), .DROP_ERR(0)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_stop_err(rx_stop_err),
    .rd_en(rd_en), .rd_data(rd_data),
    .rd_parity_err(rd_parity_err), .rd_stop_err(rd_stop_err),
    .rd_valid(rd_valid), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count),
    .overflow(overflow), .ovf_clr(ovf_clr), .err_cnt(err_cnt)
  );

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .AF_LEVEL(AF_LEVEL), .DROP_ERR(1)) dut_drop (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid_b), .rx_data(rx_data_b),
    .rx_parity_err(rx_parity_err_b), .rx_stop_err(rx_stop_err_b),
    .rd_en(rd_en_b), .rd_data(rd_data_b),
    .rd_parity_err(rd_parity_err_b), .rd_stop_err(rd_stop_err_b),
    .rd_valid(rd_valid_b), .empty(empty_b), .full(full_b),
    .almost_full(almost_full_b), .count(count_b),
    .overflow(overflow_b), .ovf_clr(ovf_clr_b), .err_cnt(err_cnt_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam bit M_DROP = 1'b0;
  logic [9:0] mq[$];
  bit         m_ovf;
  int         m_err;
  bit         m_rv;
  logic [7:0] m_rdd;
  bit         m_rpe, m_rse;

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_err = 0; m_rv = 0; m_rdd = 8'h00; m_rpe = 0; m_rse = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit pe, input bit se,
                            input bit rd, input bit clr);
    bit was_full, was_empty, ovf_ev;
    logic [9:0] e;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    ovf_ev    = 0;
    m_rv      = 0;
    if (v && (pe || se) && m_err < 255) m_err++;
    if (rd && !was_empty) begin
      e = mq.pop_front();
      m_rv = 1; m_rdd = e[7:0]; m_rpe = e[8]; m_rse = e[9];
    end
    if (v && !(M_DROP && se)) begin
      if (was_full) ovf_ev = 1;
      else mq.push_back({se, pe, d});
    end
    if (ovf_ev)   m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"},    32'(count),         32'(mq.size()));
    check({tag, ".empty"},    32'(empty),         32'(mq.size() == 0));
    check({tag, ".full"},     32'(full),          32'(mq.size() == DEPTH));
    check({tag, ".afull"},    32'(almost_full),   32'(mq.size() >= AF_LEVEL));
    check({tag, ".overflow"}, 32'(overflow),      32'(m_ovf));
    check({tag, ".err_cnt"},  32'(err_cnt),       32'(m_err));
    check({tag, ".rd_valid"}, 32'(rd_valid),      32'(m_rv));
    check({tag, ".rd_data"},  32'(rd_data),       32'(m_rdd));
    check({tag, ".rd_pe"},    32'(rd_parity_err), 32'(m_rpe));
    check({tag, ".rd_se"},    32'(rd_stop_err),   32'(m_rse));
  endtask

  // One clock on the main instance; inputs applied away from the edge,
  // outputs sampled 1 time unit after it.
  task automatic cycle(input bit v, input logic [7:0] d, input bit pe, input bit se,
                       input bit rd, input bit clr, input string tag);
    rx_valid = v; rx_data = d; rx_parity_err = pe; rx_stop_err = se;
    rd_en = rd; ovf_clr = clr;
    @(posedge clk);
    model_step(v, d, pe, se, rd, clr);
    #1;
    compare_all(tag);
    rx_valid = 0; rx_parity_err = 0; rx_stop_err = 0; rd_en = 0; ovf_clr = 0;
  endtask

  task automatic cycle_b(input bit v, input logic [7:0] d, input bit pe, input bit se,
                         input bit rd);
    rx_valid_b = v; rx_data_b = d; rx_parity_err_b = pe; rx_stop_err_b = se; rd_en_b = rd;
    @(posedge clk);
    #1;
    rx_valid_b = 0; rx_parity_err_b = 0; rx_stop_err_b = 0; rd_en_b = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         pe;
    bit         rd;
    bit         clr;
    int         cnt;
    bit         rv;
    logic [7:0] rdd;
    bit         rpe;
    bit         ovf;
    int         err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit v, logic [7:0] d, bit pe, bit rd, bit clr,
                              int cnt, bit rv, logic [7:0] rdd, bit rpe, bit ovf, int err);
    vec_t t;
    t.v = v; t.d = d; t.pe = pe; t.rd = rd; t.clr = clr;
    t.cnt = cnt; t.rv = rv; t.rdd = rdd; t.rpe = rpe; t.ovf = ovf; t.err = err;
    return t;
  endfunction

  initial begin
    // Single frame round trip, then fill/overflow/drain, then parity flag.
    tbl.push_back(mk(1, 8'h69, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 1, 8'h69, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h69, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 8'(i), 0, 0, 0, i + 1, 0, 8'h69, 0, 0, 0));
    tbl.push_back(mk(1, 8'hFF, 0, 0, 0, 8, 0, 8'h69, 0, 1, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 8'h00, 0, 1, 0, 7 - k, 1, 8'(k), 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 8'h07, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 8'h07, 0, 0, 0));
    tbl.push_back(mk(1, 8'hA5, 1, 0, 0, 1, 0, 8'h07, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 1, 8'hA5, 1, 0, 1));

    do_reset();

    foreach (tbl[i]) begin
      rx_valid = tbl[i].v; rx_data = tbl[i].d; rx_parity_err = tbl[i].pe;
      rx_stop_err = 0; rd_en = tbl[i].rd; ovf_clr = tbl[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.count", i),    32'(count),         32'(tbl[i].cnt));
      check($sformatf("vec%0d.empty", i),    32'(empty),         32'(tbl[i].cnt == 0));
      check($sformatf("vec%0d.full", i),     32'(full),          32'(tbl[i].cnt == DEPTH));
      check($sformatf("vec%0d.afull", i),    32'(almost_full),   32'(tbl[i].cnt >= AF_LEVEL));
      check($sformatf("vec%0d.rd_valid", i), 32'(rd_valid),      32'(tbl[i].rv));
      check($sformatf("vec%0d.rd_data", i),  32'(rd_data),       32'(tbl[i].rdd));
      check($sformatf("vec%0d.rd_pe", i),    32'(rd_parity_err), 32'(tbl[i].rpe));
      check($sformatf("vec%0d.rd_se", i),    32'(rd_stop_err),   32'(0));
      check($sformatf("vec%0d.overflow", i), 32'(overflow),      32'(tbl[i].ovf));
      check($sformatf("vec%0d.err_cnt", i),  32'(err_cnt),       32'(tbl[i].err));
      rx_valid = 0; rx_parity_err = 0; rd_en = 0; ovf_clr = 0;
    end

    // ---- Pointer wrap, then simultaneous write and pop at count 5 ----
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 8'(16 + i), 0, 0, 0, 0, "wrap_fill");
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 0, 1, 0, "wrap_pop");
    for (int i = 0; i < 3; i++) cycle(1, 8'(24 + i), 0, 0, 0, 0, "wrap_refill");
    check("wrap.full_after_refill", 32'(full), 32'(1));
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 0, 1, 0, "wrap_pop2");
    cycle(1, 8'h5A, 0, 0, 1, 0, "wr_rd_same");
    check("wr_rd_same.count", 32'(count), 32'(5));
    check("wr_rd_same.rd_data", 32'(rd_data), 32'(8'h16));
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 0, 0, 1, 0, "wrap_drain");
    check("wrap.last_pop", 32'(rd_data), 32'(8'h5A));

    // ---- Overflow priority over clear, and drop with rd_en ----
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 8'(i + 100), 0, 0, 0, 0, "ovf_fill");
    cycle(1, 8'hEE, 0, 0, 0, 1, "ovf_vs_clr");
    check("ovf_vs_clr.overflow", 32'(overflow), 32'(1));
    cycle(0, 8'h00, 0, 0, 0, 1, "ovf_clr_alone");
    check("ovf_clr_alone.overflow", 32'(overflow), 32'(0));
    cycle(1, 8'hDD, 0, 0, 1, 0, "drop_with_pop");
    check("drop_with_pop.count", 32'(count), 32'(7));
    check("drop_with_pop.overflow", 32'(overflow), 32'(1));

    // ---- Write and pop together while empty ----
    do_reset();
    cycle(1, 8'h42, 0, 0, 1, 0, "wr_rd_empty");
    check("wr_rd_empty.count", 32'(count), 32'(1));
    check("wr_rd_empty.rd_valid", 32'(rd_valid), 32'(0));
    cycle(0, 8'h00, 0, 0, 1, 0, "wr_rd_empty_pop");

    // ---- Asynchronous reset mid-burst ----
    do_reset();
    cycle(1, 8'h31, 0, 0, 0, 0, "burst");
    cycle(1, 8'h32, 1, 0, 1, 0, "burst");
    cycle(1, 8'h33, 0, 1, 0, 0, "burst");
    cycle(1, 8'h34, 0, 0, 0, 0, "burst");
    cycle(1, 8'h35, 0, 0, 0, 0, "burst");
    check("burst.count", 32'(count), 32'(4));
    #2;                // mid-cycle, away from any clock edge
    rst = 1'b1;
    #1;
    check("async_rst.count",    32'(count),         32'(0));
    check("async_rst.empty",    32'(empty),         32'(1));
    check("async_rst.full",     32'(full),          32'(0));
    check("async_rst.afull",    32'(almost_full),   32'(0));
    check("async_rst.overflow", 32'(overflow),      32'(0));
    check("async_rst.rd_valid", 32'(rd_valid),      32'(0));
    check("async_rst.rd_data",  32'(rd_data),       32'(0));
    check("async_rst.rd_pe",    32'(rd_parity_err), 32'(0));
    check("async_rst.rd_se",    32'(rd_stop_err),   32'(0));
    check("async_rst.err_cnt",  32'(err_cnt),       32'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(0, 8'h00, 0, 0, 1, 0, "post_rst_pop");
    check("post_rst_pop.rd_valid", 32'(rd_valid), 32'(0));

    // ---- err_cnt saturation ----
    do_reset();
    for (int i = 0; i < 260; i++) cycle(1, 8'($urandom), 1, 0, 1, 0, "err_sat");
    check("err_sat.err_cnt", 32'(err_cnt), 32'(255));

    // ---- DROP_ERR=1 instance ----
    do_reset();
    cycle_b(1, 8'h3C, 0, 1, 0);
    check("drop.se_count",    32'(count_b),    32'(0));
    check("drop.se_err",      32'(err_cnt_b),  32'(1));
    check("drop.se_overflow", 32'(overflow_b), 32'(0));
    cycle_b(1, 8'h3D, 1, 0, 0);
    check("drop.pe_count",    32'(count_b),    32'(1));
    check("drop.pe_err",      32'(err_cnt_b),  32'(2));
    for (int i = 0; i < 7; i++) cycle_b(1, 8'(i), 0, 0, 0);
    check("drop.full",        32'(full_b),     32'(1));
    cycle_b(1, 8'h77, 0, 1, 0);
    check("drop.full_se_ovf", 32'(overflow_b), 32'(0));
    check("drop.full_se_err", 32'(err_cnt_b),  32'(3));
    cycle_b(1, 8'h78, 0, 0, 0);
    check("drop.full_ovf",    32'(overflow_b), 32'(1));
    cycle_b(0, 8'h00, 0, 0, 1);
    check("drop.pop_valid",   32'(rd_valid_b),      32'(1));
    check("drop.pop_data",    32'(rd_data_b),       32'(8'h3D));
    check("drop.pop_pe",      32'(rd_parity_err_b), 32'(1));

    // ---- Randomized run against the model ----
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int phase;
      int pv, pr;
      bit v, rd, pe, se, clr;
      phase = (c / 150) % 3;
      pv = (phase == 0) ? 75 : (phase == 1) ? 25 : 50;
      pr = (phase == 0) ? 20 : (phase == 1) ? 75 : 50;
      v   = ($urandom_range(99) < pv);
      rd  = ($urandom_range(99) < pr);
      pe  = ($urandom_range(7) == 0);
      se  = ($urandom_range(7) == 0);
      clr = ($urandom_range(15) == 0);
      cycle(v, 8'($urandom), pe, se, rd, clr, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, 8, number of frame entries; power of two, 4 to 64.
REQ-002 Parameter AW, 3, pointer width; equals log2(DEPTH).
REQ-003 Parameter AF_LEVEL, 6, almost_full threshold in entries.
REQ-004 Parameter DROP_ERR, 0, discard frames carrying a stop-bit error when set to 1.
REQ-005 Port clk input 1: single clock, rising edge; the same clock that drives the UART receiver.
REQ-006 Port rst input 1: reset, asynchronous, active-high.
REQ-007 Port rx_valid input 1: one-cycle strobe, frame complete at the receiver.
REQ-008 Port rx_data input 8: received byte, sampled when rx_valid=1.
REQ-009 Port rx_parity_err input 1: parity error flag for the frame, sampled with rx_data.
REQ-010 Port rx_stop_err input 1: stop-bit error flag for the frame, sampled with rx_data.
REQ-011 Port rd_en input 1: consumer pop request.
REQ-012 Port rd_data output 8: popped byte.
REQ-013 Port rd_parity_err output 1: popped parity flag.
REQ-014 Port rd_stop_err output 1: popped stop flag.
REQ-015 Port rd_valid output 1: rd_* outputs valid this cycle.
REQ-016 Port empty output 1: count==0.
REQ-017 Port full output 1: count==DEPTH.
REQ-018 Port almost_full output 1: count>=AF_LEVEL.
REQ-019 Port count output AW+1: current occupancy.
REQ-020 Port overflow output 1: sticky flag, a frame was lost.
REQ-021 Port ovf_clr input 1: clears overflow.
REQ-022 Port err_cnt output 8: saturating count of frames received with any error.

Function
REQ-023 Storage SHALL be DEPTH entries of 10 bits {stop_err, parity_err, data}, with write and read pointers of AW bits that wrap from DEPTH-1 to 0.
REQ-024 Write: rx_valid=1 and full=0 SHALL store the entry at wr_ptr and increment wr_ptr, visible to a pop on the next cycle.
REQ-025 Write while full SHALL drop the frame, leave storage and pointers unchanged and set overflow, even when rd_en=1 in the same cycle.
REQ-026 With DROP_ERR=1, a frame with rx_stop_err=1 SHALL NOT be stored and SHALL NOT set overflow.
REQ-027 err_cnt SHALL increment, saturating at 255, for every rx_valid with parity or stop error, including dropped frames.
REQ-028 Pop: rd_en=1 and empty=0 SHALL latch the entry at rd_ptr into rd_data/rd_parity_err/rd_stop_err, assert rd_valid on the next cycle for exactly one cycle, and increment rd_ptr.
REQ-029 rd_en while empty SHALL be ignored; rd_valid=0 on the next cycle and rd_data holds its last value.
REQ-030 Simultaneous accepted write and pop SHALL leave count unchanged and move both pointers.
REQ-031 Write and rd_en together while empty SHALL accept the write and ignore the pop; count becomes 1.
REQ-032 count, empty, full and almost_full SHALL be registered and consistent with each other in every cycle.
REQ-033 ovf_clr=1 SHALL clear overflow on the next edge; a same-cycle overflow event SHALL take priority and leave overflow set.
REQ-034 Latency SHALL be 1 cycle from rd_en to rd_valid; an entry written at cycle N SHALL be poppable at cycle N+1.

Reset
REQ-035 rst=1 SHALL immediately force wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, overflow=0, rd_valid=0, rd_data=0, rd_parity_err=0, rd_stop_err=0 and err_cnt=0.
REQ-036 Reset during operation SHALL discard all stored frames; storage contents need not be cleared.
REQ-037 After rst deasserts, the first rx_valid on or after the next rising edge SHALL be accepted.

Verification
REQ-038 Reset, then rx_valid with 0x69 and no errors; rd_en next cycle -> rd_valid=1 one cycle later, rd_data=0x69, flags 0, empty=1.
REQ-039 Write 8 frames 0x00..0x07 -> full=1, count=8, almost_full asserted once count reaches 6; ninth frame 0xFF -> overflow=1, and popping 8 times returns 0x00..0x07 in order.
REQ-040 Fill to 8, wrap pointers by popping 3 and writing 3 -> order preserved across the wrap; then simultaneous write and pop at count=5 -> count stays 5.
REQ-041 rx_valid with parity_err=1 and 0xA5, DROP_ERR=0 -> entry stored with rd_parity_err=1 and err_cnt=1; with DROP_ERR=1 and stop_err=1 -> not stored, err_cnt increments, overflow=0.
REQ-042 Assert ovf_clr in the same cycle as a full-drop -> overflow stays 1; ovf_clr alone on the next cycle -> overflow=0.
REQ-043 Assert rst mid-burst with count=4 -> all outputs at reset values immediately, without waiting for a clock edge; rd_en after release -> rd_valid=0.
